// File: rtl/time_sync_rx_parser_if.sv
// AXI-Stream receive bus carrying frames into the time-sync parser.
interface time_sync_rx_parser_if;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready
  );
endinterface

// File: rtl/time_sync_rx_parser.sv
// Receive-side SYNC frame parser: extracts the master timestamp, adds path
// delay with ns rollover, and pulses sync_wr_en two cycles after tlast.
module time_sync_rx_parser #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter logic [7:0]  MSG_SYNC  = 8'h01
) (
  input  logic                   clk,
  input  logic                   rst,
  time_sync_rx_parser_if.slave   s_axis,
  input  logic                   enable,
  input  logic [29:0]            delay_ns,
  input  logic [15:0]            delay_frac,
  output logic                   sync_wr_en,
  output logic [95:0]            sync_wr_ts,
  output logic [31:0]            rx_sync_count,
  output logic [31:0]            rx_drop_count
);

  localparam int unsigned SEC_W  = 48;
  localparam int unsigned NS_W   = 30;
  localparam int unsigned FRAC_W = 16;
  localparam logic [31:0]   NS_PER_SEC    = 32'd1_000_000_000;
  localparam logic [NS_W:0] NS_PER_SEC_31 = (NS_W+1)'(1_000_000_000);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_SKIP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [15:0]         eth_q, eth_d;
  logic [7:0]          msg_q, msg_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [31:0]         ns_q, ns_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic                have3_q, have3_d;
  logic                keep_ok_q, keep_ok_d;
  logic                frame_end_c;
  logic                accept_c;
  logic                drop_c;

  logic                s1_vld_q;
  logic [SEC_W-1:0]    s1_sec_q;
  logic [FRAC_W:0]     s1_frac_sum_q;
  logic [NS_W:0]       s1_ns_sum_q;
  logic [FRAC_W:0]     frac_sum_c;
  logic [NS_W:0]       ns_sum_c;
  logic                roll_c;
  logic [NS_W-1:0]     ns_out_c;
  logic [SEC_W-1:0]    sec_out_c;

  logic                sync_wr_en_q;
  logic [95:0]         sync_wr_ts_q;
  logic [31:0]         sync_cnt_q;
  logic [31:0]         drop_cnt_q;

  logic [63:0]         d;
  logic                unused_keep_c;

  // Sink never stalls the stream.
  assign s_axis.s_axis_tready = 1'b1;
  assign d             = s_axis.s_axis_tdata;
  assign unused_keep_c = ^s_axis.s_axis_tkeep[7:4];

  // Next-state: beat tracking, header field capture and frame verdict.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    eth_d       = eth_q;
    msg_d       = msg_q;
    sec_d       = sec_q;
    ns_d        = ns_q;
    frac_d      = frac_q;
    have3_d     = have3_q;
    keep_ok_d   = keep_ok_q;
    frame_end_c = 1'b0;
    if (s_axis.s_axis_tvalid) begin
      unique case (state_q)
        ST_IDLE: begin
          have3_d   = 1'b0;
          keep_ok_d = 1'b0;
          if (!s_axis.s_axis_tlast) begin
            state_d = ST_HDR;
            beat_d  = 2'd1;
          end
        end
        ST_HDR: begin
          case (beat_q)
            2'd1: begin
              eth_d = {d[39:32], d[47:40]};
              msg_d = d[55:48];
            end
            2'd2: begin
              sec_d        = {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
              ns_d[31:16]  = {d[55:48], d[63:56]};
            end
            2'd3: begin
              ns_d[15:0] = {d[7:0], d[15:8]};
              frac_d     = {d[23:16], d[31:24]};
              have3_d    = 1'b1;
              keep_ok_d  = (s_axis.s_axis_tkeep[3:0] == 4'hF);
            end
            default: ;
          endcase
          if (s_axis.s_axis_tlast) begin
            frame_end_c = 1'b1;
            state_d     = ST_IDLE;
            beat_d      = 2'd0;
          end else if (beat_q == 2'd3) begin
            state_d = ST_SKIP;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
        ST_SKIP: begin
          if (s_axis.s_axis_tlast) begin
            frame_end_c = 1'b1;
            state_d     = ST_IDLE;
            beat_d      = 2'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Verdict uses the freshly captured fields so a 4-beat frame is judged on its own tlast.
  assign accept_c = frame_end_c && (eth_d == ETHERTYPE) && (msg_d == MSG_SYNC) &&
                    have3_d && keep_ok_d && !s_axis.s_axis_tuser && (ns_d < NS_PER_SEC);
  assign drop_c   = frame_end_c && (eth_d == ETHERTYPE) && !accept_c;

  // Stage-1 compensation sums; accepted ns is below 1e9 so 30 bits suffice.
  assign frac_sum_c = (FRAC_W+1)'(frac_d) + (FRAC_W+1)'(delay_frac);
  assign ns_sum_c   = (NS_W+1)'(ns_d[NS_W-1:0]) + (NS_W+1)'(delay_ns) +
                      (NS_W+1)'(frac_sum_c[FRAC_W]);

  // Stage-2 normalisation into [0, 1e9) with seconds carry.
  assign roll_c    = (s1_ns_sum_q >= NS_PER_SEC_31);
  assign ns_out_c  = roll_c ? NS_W'(s1_ns_sum_q - NS_PER_SEC_31) : s1_ns_sum_q[NS_W-1:0];
  assign sec_out_c = roll_c ? s1_sec_q + SEC_W'(1) : s1_sec_q;

  // State, capture, pipeline and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      beat_q        <= 2'd0;
      eth_q         <= '0;
      msg_q         <= '0;
      sec_q         <= '0;
      ns_q          <= '0;
      frac_q        <= '0;
      have3_q       <= 1'b0;
      keep_ok_q     <= 1'b0;
      s1_vld_q      <= 1'b0;
      s1_sec_q      <= '0;
      s1_frac_sum_q <= '0;
      s1_ns_sum_q   <= '0;
      sync_wr_en_q  <= 1'b0;
      sync_wr_ts_q  <= '0;
      sync_cnt_q    <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      eth_q     <= eth_d;
      msg_q     <= msg_d;
      sec_q     <= sec_d;
      ns_q      <= ns_d;
      frac_q    <= frac_d;
      have3_q   <= have3_d;
      keep_ok_q <= keep_ok_d;
      s1_vld_q  <= accept_c && enable;
      if (accept_c) begin
        s1_sec_q      <= sec_d;
        s1_frac_sum_q <= frac_sum_c;
        s1_ns_sum_q   <= ns_sum_c;
        sync_cnt_q    <= sync_cnt_q + 32'd1;
      end
      if (drop_c) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
      sync_wr_en_q <= s1_vld_q;
      if (s1_vld_q) begin
        sync_wr_ts_q <= {sec_out_c, 2'b00, ns_out_c, s1_frac_sum_q[FRAC_W-1:0]};
      end
    end
  end

  assign sync_wr_en    = sync_wr_en_q;
  assign sync_wr_ts    = sync_wr_ts_q;
  assign rx_sync_count = sync_cnt_q;
  assign rx_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_time_sync_rx_parser.sv
// Bench for time_sync_rx_parser: directed table, reset corner, random frames vs model.
module tb_time_sync_rx_parser;
  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [29:0] delay_ns;
  logic [15:0] delay_frac;
  logic        sync_wr_en;
  logic [95:0] sync_wr_ts;
  logic [31:0] rx_sync_count;
  logic [31:0] rx_drop_count;

  time_sync_rx_parser_if bus();

  time_sync_rx_parser dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis        (bus),
    .enable        (enable),
    .delay_ns      (delay_ns),
    .delay_frac    (delay_frac),
    .sync_wr_en    (sync_wr_en),
    .sync_wr_ts    (sync_wr_ts),
    .rx_sync_count (rx_sync_count),
    .rx_drop_count (rx_drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [95:0] ts;
  } exp_t;

  typedef struct {
    logic [15:0] eth;
    logic [7:0]  msg;
    logic [47:0] s;
    logic [31:0] ns;
    logic [15:0] frac;
    logic [29:0] dns;
    logic [15:0] dfrac;
    int          nbeats;
    bit          tuser;
    logic [3:0]  keep3;
    bit          en;
    int          gap;
    int          exp_pulses;
    logic [95:0] exp_ts;
    int          exp_sync;
    int          exp_drop;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[11];
  logic [7:0]  fb[64];
  int          cyc;
  int          checks;
  int          failures;
  int          pulse_cnt;
  int          exp_sync;
  int          exp_drop;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Sample outputs mid-cycle against the expected pulse schedule, then advance one clock.
  task automatic tick();
    bit          exp_en;
    logic [95:0] exp_ts;
    exp_en = 1'b0;
    exp_ts = '0;
    @(negedge clk);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_en = 1'b1;
      exp_ts = exp_q[0].ts;
      void'(exp_q.pop_front());
    end
    checks++;
    if (sync_wr_en !== exp_en) begin
      failures++;
      $display("FAIL pulse cyc=%0d got=%b exp=%b", cyc, sync_wr_en, exp_en);
    end
    if (exp_en) check("pulse_ts", sync_wr_ts, exp_ts);
    if (sync_wr_en === 1'b1) pulse_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    bus.s_axis_tdata  = {$urandom, $urandom};
    bus.s_axis_tkeep  = 8'($urandom);
  endtask

  task automatic build_frame(input logic [15:0] eth, input logic [7:0] msg,
                             input logic [47:0] s, input logic [31:0] ns,
                             input logic [15:0] frac);
    for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
    fb[12] = eth[15:8];
    fb[13] = eth[7:0];
    fb[14] = msg;
    for (int i = 0; i < 6; i++) fb[16+i] = s[47-8*i -: 8];
    for (int i = 0; i < 4; i++) fb[22+i] = ns[31-8*i -: 8];
    fb[26] = frac[15:8];
    fb[27] = frac[7:0];
  endtask

  // Reference: judge the frame from its byte image and schedule the expected pulse.
  task automatic model_frame(input int nbeats, input bit tu, input logic [3:0] keep3);
    logic [15:0]     eth;
    logic [47:0]     s;
    logic [31:0]     ns;
    logic [15:0]     frac;
    longint unsigned tot;
    longint unsigned ns_o;
    logic [47:0]     s_o;
    bit              ok;
    exp_t            e;
    eth  = {fb[12], fb[13]};
    s    = {fb[16], fb[17], fb[18], fb[19], fb[20], fb[21]};
    ns   = {fb[22], fb[23], fb[24], fb[25]};
    frac = {fb[26], fb[27]};
    if (nbeats < 2 || eth != 16'h88B5) return;
    ok = (nbeats >= 4) && (keep3 == 4'hF) && (fb[14] == 8'h01) && !tu && (ns < NS_PER_SEC);
    if (!ok) begin
      exp_drop++;
      return;
    end
    exp_sync++;
    if (!enable) return;
    tot  = (longint'(ns) << 16) + longint'(frac) + (longint'(delay_ns) << 16) + longint'(delay_frac);
    ns_o = tot >> 16;
    s_o  = s;
    if (ns_o >= 64'd1_000_000_000) begin
      ns_o = ns_o - 64'd1_000_000_000;
      s_o  = s + 48'd1;
    end
    e.cyc = cyc + 2;
    e.ts  = {s_o, 2'b00, ns_o[29:0], tot[15:0]};
    exp_q.push_back(e);
  endtask

  task automatic drive_beat(input int b, input bit last, input bit tu, input logic [3:0] keep3);
    bus.s_axis_tvalid = 1'b1;
    for (int k = 0; k < 8; k++) bus.s_axis_tdata[8*k +: 8] = fb[8*b+k];
    bus.s_axis_tkeep  = (b == 3) ? {4'hF, keep3} : 8'hFF;
    bus.s_axis_tlast  = last;
    bus.s_axis_tuser  = last ? tu : 1'($urandom);
  endtask

  task automatic send_frame(input int nbeats, input bit tu, input logic [3:0] keep3, input int gap);
    for (int b = 0; b < nbeats; b++) begin
      while (gap > 0 && $urandom_range(99) < 32'(gap)) begin
        idle();
        tick();
      end
      drive_beat(b, b == nbeats - 1, tu, keep3);
      if (b == nbeats - 1) model_frame(nbeats, tu, keep3);
      tick();
    end
    idle();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pulse_cnt = 0;
    exp_sync  = 0;
    exp_drop  = 0;
    cyc       = 0;
    rst        = 1'b1;
    enable     = 1'b1;
    delay_ns   = '0;
    delay_frac = '0;
    idle();

    //        eth       msg    s                   ns                   frac     dns     dfrac    nb tu keep en gap pul exp_ts                                                  sync drop
    vecs[0]  = '{16'h88B5, 8'h01, 48'h10,            32'd500_000_000,     16'h8000, 30'd0,    16'h0,    4, 0, 4'hF, 1, 0, 1, {48'h10, 2'b0, 30'd500_000_000, 16'h8000},            1, 0};
    vecs[1]  = '{16'h88B5, 8'h01, 48'h10,            32'd999_999_990,     16'hC000, 30'd9,    16'h4000, 4, 0, 4'hF, 1, 0, 1, {48'h11, 2'b0, 30'd0, 16'h0000},                      2, 0};
    vecs[2]  = '{16'h88B5, 8'h01, 48'hFFFF_FFFF_FFFF, 32'd999_999_999,    16'h1234, 30'd1,    16'h0,    4, 0, 4'hF, 1, 0, 1, {48'h0, 2'b0, 30'd0, 16'h1234},                       3, 0};
    vecs[3]  = '{16'h88B5, 8'h01, 48'h5,             32'd100,             16'h0,    30'd0,    16'h0,    5, 1, 4'hF, 1, 0, 0, {48'h0, 2'b0, 30'd0, 16'h1234},                       3, 1};
    vecs[4]  = '{16'h88B5, 8'h01, 48'h5,             32'd1_000_000_000,   16'h0,    30'd0,    16'h0,    4, 0, 4'hF, 1, 0, 0, {48'h0, 2'b0, 30'd0, 16'h1234},                       3, 2};
    vecs[5]  = '{16'h88B5, 8'h01, 48'h5,             32'd100,             16'h0,    30'd0,    16'h0,    3, 0, 4'hF, 1, 0, 0, {48'h0, 2'b0, 30'd0, 16'h1234},                       3, 3};
    vecs[6]  = '{16'h0800, 8'h01, 48'h5,             32'd100,             16'h0,    30'd0,    16'h0,    4, 0, 4'hF, 1, 0, 0, {48'h0, 2'b0, 30'd0, 16'h1234},                       3, 3};
    vecs[7]  = '{16'h88B5, 8'h01, 48'h1234_5678_9ABC, 32'd123_456_789,    16'h00FF, 30'd1000, 16'hFF01, 8, 0, 4'hF, 1, 50, 1, {48'h1234_5678_9ABC, 2'b0, 30'd123_457_790, 16'h0}, 4, 3};
    vecs[8]  = '{16'h88B5, 8'h01, 48'h7,             32'd7,               16'h7,    30'd0,    16'h0,    4, 0, 4'h7, 1, 0, 0, {48'h1234_5678_9ABC, 2'b0, 30'd123_457_790, 16'h0}, 4, 4};
    vecs[9]  = '{16'h88B5, 8'h02, 48'h7,             32'd7,               16'h7,    30'd0,    16'h0,    4, 0, 4'hF, 1, 0, 0, {48'h1234_5678_9ABC, 2'b0, 30'd123_457_790, 16'h0}, 4, 5};
    vecs[10] = '{16'h88B5, 8'h01, 48'h9,             32'd9,               16'h9,    30'd0,    16'h0,    4, 0, 4'hF, 0, 0, 0, {48'h1234_5678_9ABC, 2'b0, 30'd123_457_790, 16'h0}, 5, 5};

    // Reset values.
    repeat (3) tick();
    check("rst_tready", 96'(bus.s_axis_tready), 96'd1);
    check("rst_ts", sync_wr_ts, 96'd0);
    check("rst_sync_cnt", 96'(rx_sync_count), 96'd0);
    check("rst_drop_cnt", 96'(rx_drop_count), 96'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Directed table.
    for (int v = 0; v < 11; v++) begin
      int p0;
      p0         = pulse_cnt;
      enable     = vecs[v].en;
      delay_ns   = vecs[v].dns;
      delay_frac = vecs[v].dfrac;
      build_frame(vecs[v].eth, vecs[v].msg, vecs[v].s, vecs[v].ns, vecs[v].frac);
      send_frame(vecs[v].nbeats, vecs[v].tuser, vecs[v].keep3, vecs[v].gap);
      repeat (4) tick();
      check($sformatf("vec%0d_ts", v), sync_wr_ts, vecs[v].exp_ts);
      check($sformatf("vec%0d_sync_cnt", v), 96'(rx_sync_count), 96'(vecs[v].exp_sync));
      check($sformatf("vec%0d_drop_cnt", v), 96'(rx_drop_count), 96'(vecs[v].exp_drop));
      check($sformatf("vec%0d_pulses", v), 96'(pulse_cnt - p0), 96'(vecs[v].exp_pulses));
    end
    enable = 1'b1;

    // Reset asserted on beat 2 of a valid frame.
    delay_ns   = '0;
    delay_frac = '0;
    build_frame(16'h88B5, 8'h01, 48'h99, 32'd99, 16'h99);
    drive_beat(0, 1'b0, 1'b0, 4'hF);
    tick();
    drive_beat(1, 1'b0, 1'b0, 4'hF);
    tick();
    drive_beat(2, 1'b0, 1'b0, 4'hF);
    rst = 1'b1;
    exp_q.delete();
    exp_sync = 0;
    exp_drop = 0;
    tick();
    idle();
    tick();
    check("midrst_en", 96'(sync_wr_en), 96'd0);
    check("midrst_ts", sync_wr_ts, 96'd0);
    check("midrst_sync_cnt", 96'(rx_sync_count), 96'd0);
    check("midrst_drop_cnt", 96'(rx_drop_count), 96'd0);
    check("midrst_tready", 96'(bus.s_axis_tready), 96'd1);
    rst = 1'b0;
    repeat (3) tick();
    begin
      int p0;
      p0 = pulse_cnt;
      build_frame(16'h88B5, 8'h01, 48'h42, 32'd7, 16'h0001);
      send_frame(4, 1'b0, 4'hF, 0);
      repeat (4) tick();
      check("post_rst_ts", sync_wr_ts, {48'h42, 2'b0, 30'd7, 16'h0001});
      check("post_rst_sync_cnt", 96'(rx_sync_count), 96'd1);
      check("post_rst_pulses", 96'(pulse_cnt - p0), 96'd1);
    end

    // Random frames against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [15:0] eth;
      logic [7:0]  msg;
      logic [31:0] ns;
      int          r;
      eth = ($urandom_range(9) < 8) ? 16'h88B5 : 16'($urandom);
      msg = ($urandom_range(9) < 8) ? 8'h01 : 8'($urandom);
      r   = int'($urandom_range(9));
      if (r < 6)      ns = $urandom_range(999_999_999);
      else if (r < 9) ns = 32'd999_999_000 + $urandom_range(999);
      else            ns = 32'd1_000_000_000 + $urandom_range(1000);
      delay_ns   = ($urandom_range(1) == 0) ? 30'($urandom_range(999_999_999))
                                            : 30'(32'd999_999_000 + $urandom_range(999));
      delay_frac = 16'($urandom);
      enable     = ($urandom_range(4) != 0);
      build_frame(eth, msg, {16'($urandom), $urandom}, ns, 16'($urandom));
      send_frame(int'($urandom_range(8, 1)), ($urandom_range(9) == 0),
                 ($urandom_range(9) == 0) ? 4'($urandom) : 4'hF, int'($urandom_range(40)));
    end
    repeat (5) tick();
    check("rand_sync_cnt", 96'(rx_sync_count), 96'(exp_sync));
    check("rand_drop_cnt", 96'(rx_drop_count), 96'(exp_drop));
    check("rand_pending", 96'(exp_q.size()), 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_sync_rx_parser.md
# time_sync_rx_parser

Per-interface receive-side parser for time-sync SYNC frames. It consumes one 64-bit AXI-Stream receive path and extracts the 96-bit master timestamp. It adds a configured path-delay compensation with nanosecond-rollover normalisation, then emits a one-cycle `sync_wr_en` pulse with `sync_wr_ts`. One instance per interface; the outputs feed one lane of the PHC-write arbitration stage's `sync_wr_en`/`sync_wr_ts` bus.

## Interface
- `ETHERTYPE`, 16'h88B5, EtherType identifying time-sync frames
- `MSG_SYNC`, 8'h01, message-type byte value for SYNC
- `clk` input 1: clock
- `rst` input 1: reset, asynchronous, active-high
- `s_axis_tdata` input 64: frame data; byte k of a beat is `tdata[8k+7:8k]`
- `s_axis_tkeep` input 8: byte enables
- `s_axis_tvalid` input 1: beat valid
- `s_axis_tready` output 1: constant 1 (sink never back-pressures)
- `s_axis_tlast` input 1: last beat of frame
- `s_axis_tuser` input 1: bad-frame flag, sampled on the tlast beat
- `enable` input 1: 0 = frames parsed and counted, no pulse issued
- `delay_ns` input 30: path-delay nanoseconds; must be < 1e9, quasi-static
- `delay_frac` input 16: path-delay fractional ns (units of 2^-16 ns)
- `sync_wr_en` output 1: one-cycle pulse, timestamp valid
- `sync_wr_ts` output 96: [95:48] seconds, [47:46] zero, [45:16] ns, [15:0] frac ns
- `rx_sync_count` output 32: accepted SYNC frames, wrapping
- `rx_drop_count` output 32: rejected time-sync-EtherType frames, wrapping

## Operation
- Frame byte layout, byte offset from frame start; multi-byte fields big-endian:
  - 12–13: EtherType
  - 14: message type
  - 16–21: seconds (48 b)
  - 22–25: ns (32 b)
  - 26–27: frac (16 b)
- Beat counter `beat` (0..3, saturating at 3) advances on each accepted beat and clears after tlast.
- Capture per beat:
  - beat 1: EtherType = {byte12, byte13}; msgtype = byte14
  - beat 2: seconds, ns[31:16]
  - beat 3: ns[15:0], frac
- Beats after beat 3 are ignored until tlast.
- States:
  - IDLE: awaiting beat 0.
  - HDR: beats 1..3.
  - SKIP: beat>3, waiting for tlast.
  - Any tlast returns to IDLE.
- Frame is accepted on tlast only if all hold:
  - ≥4 beats, and the beat-3 `tkeep[3:0]` = 4'hF.
  - EtherType == `ETHERTYPE` and msgtype == `MSG_SYNC`.
  - `tuser` = 0 on the tlast beat.
  - Received ns < 1,000,000,000.
- Rejection rules:
  - A frame whose EtherType matches but fails any other check increments `rx_drop_count`.
  - A frame with a non-matching EtherType, or a runt shorter than 2 beats, is silently ignored.
- Compensation, stage 1 (registered):
  - `frac_sum` = frac + `delay_frac` (17 b); carry c0 = `frac_sum[16]`.
  - `ns_sum` = ns[29:0] + `delay_ns` + c0 (31 b).
- Normalisation, stage 2 (registered):
  - If `ns_sum` ≥ 1e9: ns_out = `ns_sum` − 1e9 and s_out = s + 1, with 48-bit wrap.
  - Otherwise: ns_out = `ns_sum` and s_out = s.
  - frac_out = `frac_sum[15:0]`.
- Accepted frame with `enable`=1: `sync_wr_en`=1 for one cycle and `sync_wr_ts` updated. `sync_wr_ts` holds its value until the next accepted frame.
- `rx_sync_count` increments on every accepted frame regardless of `enable`.

## Timing
- Reset values:
  - `sync_wr_en`=0, `sync_wr_ts`=0, both counters 0, state IDLE, beat 0.
  - `s_axis_tready`=1 during and after reset.
- Latency: tlast accepted at cycle N → `sync_wr_en` high at cycle N+2, and `sync_wr_ts` valid from N+2.
- Back-to-back frames: the minimum valid frame is 4 beats and the pipeline depth is 2, so pulses never overlap. No output pulse is ever lost or merged.
- tvalid gaps are allowed anywhere; only accepted beats advance state.
- `enable` is sampled at cycle N. A change after N does not affect a frame already in the pipeline.
- `delay_ns`/`delay_frac` are sampled at stage 1 (cycle N).
- Reset mid-frame: state returns to IDLE and the pipeline is flushed, with no pulse. The stream is required to restart at a frame boundary after reset deassertion.
- Counter wrap: 32'hFFFFFFFF + 1 → 0, with no flag.

## Test plan
- Valid SYNC, s=0x000000000010, ns=500,000,000, frac=0x8000, delay 0 → `sync_wr_en` pulse at N+2; ts = {48'h10, 2'b0, 30'd500000000, 16'h8000}; `rx_sync_count`=1.
- ns=999,999,990, frac=0xC000, delay_ns=9, delay_frac=0x4000 → frac carry, ns 1e9 rollover; ts s=0x11, ns=0, frac=0x0000.
- s=48'hFFFF_FFFF_FFFF, ns=999,999,999, delay_ns=1 → s wraps to 0, ns=0.
- Matching EtherType frame with tuser=1 on tlast, then one with ns=1,000,000,000, then a 3-beat runt → no pulses; `rx_drop_count`=3.
- EtherType 0x0800 frame, then a valid 8-beat SYNC with tvalid gaps → first ignored (counters unchanged); second pulses 2 cycles after its tlast.
- `enable`=0 with a valid frame → no pulse, `rx_sync_count` increments. Assert rst on beat 2 of the next frame → no pulse, all outputs 0; a subsequent clean frame parses correctly.
